// File: rtl/credential_entry_fsm.sv
// Session controller ahead of the account authenticator: latches the card account,
// assembles a decimal PIN from keypad digits and enforces the retry/lockout policy.
module credential_entry_fsm #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int PIN_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCK_CYCLES    = 5000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              card_valid,
  input  logic [3:0]                        card_acc_num,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              session_end,
  input  logic                              acc_found_stat,
  input  logic                              acc_auth_stat,
  output logic [3:0]                        acc_num,
  output logic [15:0]                       pin,
  output logic [2:0]                        digit_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
  output logic                              auth_ok,
  output logic                              auth_fail,
  output logic                              timeout,
  output logic                              session_active,
  output logic                              locked
);

  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic ACCOUNT_FOUND         = 1'b1;
  localparam logic ACCOUNT_AUTHENTICATED = 1'b1;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER_PIN,
    S_CHECK,
    S_GRANTED,
    S_LOCKED
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] idle_cnt;
  logic [LCK_W-1:0] lock_cnt;

  // Decimal shift-in; at most four digits so the result never exceeds 9999.
  function automatic logic [15:0] append_digit(input logic [15:0] value,
                                               input logic [3:0]  digit);
    append_digit = value * 16'd10 + {12'd0, digit};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      acc_num        <= '0;
      pin            <= '0;
      digit_count    <= '0;
      attempts_left  <= ATT_W'(MAX_ATTEMPTS);
      auth_ok        <= 1'b0;
      auth_fail      <= 1'b0;
      timeout        <= 1'b0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      idle_cnt       <= '0;
      lock_cnt       <= '0;
    end else begin
      auth_ok   <= 1'b0;
      auth_fail <= 1'b0;
      timeout   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (card_valid) begin
            acc_num       <= card_acc_num;
            pin           <= '0;
            digit_count   <= '0;
            attempts_left <= ATT_W'(MAX_ATTEMPTS);
            idle_cnt      <= '0;
            state         <= S_ENTER_PIN;
          end
        end

        S_ENTER_PIN: begin
          if (key_valid) begin
            // Any key press, even an unrecognised code, counts as activity.
            idle_cnt <= '0;
            if (key_code <= 4'd9) begin
              if (digit_count < 3'(PIN_DIGITS)) begin
                pin         <= append_digit(pin, key_code);
                digit_count <= digit_count + 3'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              pin         <= '0;
              digit_count <= '0;
            end else if (key_code == KEY_ENTER) begin
              if (digit_count == 3'(PIN_DIGITS))
                state <= S_CHECK;
            end else if (key_code == KEY_CANCEL) begin
              acc_num     <= '0;
              pin         <= '0;
              digit_count <= '0;
              state       <= S_IDLE;
            end
          end else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout     <= 1'b1;
            acc_num     <= '0;
            pin         <= '0;
            digit_count <= '0;
            idle_cnt    <= '0;
            state       <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + TMO_W'(1);
          end
        end

        // acc_num/pin are registered, so the authenticator status is settled here.
        S_CHECK: begin
          pin         <= '0;
          digit_count <= '0;
          if (acc_found_stat == ACCOUNT_FOUND && acc_auth_stat == ACCOUNT_AUTHENTICATED) begin
            auth_ok        <= 1'b1;
            session_active <= 1'b1;
            state          <= S_GRANTED;
          end else if (acc_found_stat != ACCOUNT_FOUND) begin
            auth_fail <= 1'b1;
            acc_num   <= '0;
            state     <= S_IDLE;
          end else begin
            auth_fail     <= 1'b1;
            attempts_left <= attempts_left - ATT_W'(1);
            if (attempts_left == ATT_W'(1)) begin
              locked   <= 1'b1;
              lock_cnt <= '0;
              state    <= S_LOCKED;
            end else begin
              idle_cnt <= '0;
              state    <= S_ENTER_PIN;
            end
          end
        end

        S_GRANTED: begin
          if (session_end || (key_valid && key_code == KEY_CANCEL)) begin
            session_active <= 1'b0;
            acc_num        <= '0;
            state          <= S_IDLE;
          end
        end

        S_LOCKED: begin
          if (lock_cnt == LCK_W'(LOCK_CYCLES - 1)) begin
            locked        <= 1'b0;
            attempts_left <= ATT_W'(MAX_ATTEMPTS);
            acc_num       <= '0;
            lock_cnt      <= '0;
            state         <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LCK_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_credential_entry_fsm.sv
// Bench for credential_entry_fsm: vector table, hand-written corner sequences and
// randomized sessions, all compared every cycle against a digit-queue reference model.
module tb_credential_entry_fsm;

  localparam int MAX_ATT = 3;
  localparam int PD      = 4;
  localparam int TMO     = 40;
  localparam int LCK     = 60;

  logic        clk = 1'b0;
  logic        rst, card_valid, key_valid, session_end;
  logic        acc_found_stat, acc_auth_stat;
  logic [3:0]  card_acc_num, key_code, acc_num;
  logic [15:0] pin;
  logic [2:0]  digit_count;
  logic [1:0]  attempts_left;
  logic        auth_ok, auth_fail, timeout, session_active, locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  credential_entry_fsm #(
    .MAX_ATTEMPTS  (MAX_ATT),
    .PIN_DIGITS    (PD),
    .TIMEOUT_CYCLES(TMO),
    .LOCK_CYCLES   (LCK)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .card_valid    (card_valid),
    .card_acc_num  (card_acc_num),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .session_end   (session_end),
    .acc_found_stat(acc_found_stat),
    .acc_auth_stat (acc_auth_stat),
    .acc_num       (acc_num),
    .pin           (pin),
    .digit_count   (digit_count),
    .attempts_left (attempts_left),
    .auth_ok       (auth_ok),
    .auth_fail     (auth_fail),
    .timeout       (timeout),
    .session_active(session_active),
    .locked        (locked)
  );

  // Authenticator stand-in: accounts 0..9 exist, each with one stored PIN.
  function automatic int pin_of(input int a);
    case (a)
      0: return 1234;
      1: return 4321;
      2: return 2345;
      3: return 3456;
      4: return 1000;
      5: return 5555;
      6: return 0;
      7: return 7;
      8: return 9999;
      9: return 8888;
      default: return -1;
    endcase
  endfunction

  assign acc_found_stat = (acc_num < 4'd10);
  assign acc_auth_stat  = acc_found_stat && (int'(pin) == pin_of(int'(acc_num)));

  // Reference model: session mode plus the typed digits held as a queue.
  typedef enum int {M_IDLE, M_ENTRY, M_CHECK, M_GRANTED, M_LOCKED} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_acc = 0;
  int    m_digits[$];
  int    m_tries = MAX_ATT;
  int    m_quiet = 0;
  int    m_lock_left = 0;
  int    m_ok = 0, m_fail = 0, m_tmo = 0;

  function automatic int m_pin();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  task automatic m_abandon();
    m_mode = M_IDLE;
    m_acc  = 0;
    m_digits.delete();
  endtask

  task automatic model_step();
    int kc;
    int value;
    kc = int'(key_code);
    m_ok = 0; m_fail = 0; m_tmo = 0;
    if (rst) begin
      m_mode = M_IDLE; m_acc = 0; m_digits.delete();
      m_tries = MAX_ATT; m_quiet = 0; m_lock_left = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (card_valid) begin
        m_acc = int'(card_acc_num); m_digits.delete();
        m_tries = MAX_ATT; m_quiet = 0; m_mode = M_ENTRY;
      end
      M_ENTRY: begin
        if (key_valid) begin
          m_quiet = 0;
          if (kc <= 9) begin
            if (m_digits.size() < PD) m_digits.push_back(kc);
          end else if (kc == 10) begin
            if (m_digits.size() == PD) m_mode = M_CHECK;
          end else if (kc == 11) begin
            m_digits.delete();
          end else if (kc == 12) begin
            m_abandon();
          end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) begin
            m_tmo = 1;
            m_abandon();
          end
        end
      end
      M_CHECK: begin
        value = m_pin();
        m_digits.delete();
        if (m_acc < 10 && value == pin_of(m_acc)) begin
          m_ok = 1; m_mode = M_GRANTED;
        end else if (m_acc >= 10) begin
          m_fail = 1; m_acc = 0; m_mode = M_IDLE;
        end else begin
          m_fail = 1; m_tries--;
          if (m_tries == 0) begin
            m_mode = M_LOCKED; m_lock_left = LCK;
          end else begin
            m_mode = M_ENTRY; m_quiet = 0;
          end
        end
      end
      M_GRANTED: if (session_end || (key_valid && kc == 12)) begin
        m_acc = 0; m_mode = M_IDLE;
      end
      M_LOCKED: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_mode = M_IDLE; m_tries = MAX_ATT; m_acc = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model.acc_num",        32'(acc_num),        m_acc);
    check("model.pin",            32'(pin),            m_pin());
    check("model.digit_count",    32'(digit_count),    m_digits.size());
    check("model.attempts_left",  32'(attempts_left),  m_tries);
    check("model.auth_ok",        32'(auth_ok),        m_ok);
    check("model.auth_fail",      32'(auth_fail),      m_fail);
    check("model.timeout",        32'(timeout),        m_tmo);
    check("model.session_active", 32'(session_active), (m_mode == M_GRANTED) ? 1 : 0);
    check("model.locked",         32'(locked),         (m_mode == M_LOCKED) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic drive(input int cv, input int acc, input int kv, input int kc, input int se);
    card_valid   = (cv != 0);
    card_acc_num = 4'(acc);
    key_valid    = (kv != 0);
    key_code     = 4'(kc);
    session_end  = (se != 0);
    tick();
    card_valid  = 1'b0;
    key_valid   = 1'b0;
    session_end = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic key(input int k);
    drive(0, 0, 1, k, 0);
  endtask

  task automatic card(input int a);
    drive(1, a, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".acc_num"},        32'(acc_num),        0);
    check({tag, ".pin"},            32'(pin),            0);
    check({tag, ".digit_count"},    32'(digit_count),    0);
    check({tag, ".attempts_left"},  32'(attempts_left),  MAX_ATT);
    check({tag, ".auth_ok"},        32'(auth_ok),        0);
    check({tag, ".auth_fail"},      32'(auth_fail),      0);
    check({tag, ".timeout"},        32'(timeout),        0);
    check({tag, ".session_active"}, 32'(session_active), 0);
    check({tag, ".locked"},         32'(locked),         0);
  endtask

  typedef struct {
    int cv, acc, kv, kc, se;
    int e_acc, e_pin, e_dc, e_att, e_ok, e_fail, e_act;
  } vec_t;
  vec_t vt[$];

  task automatic add(input int cv, input int acc, input int kv, input int kc, input int se,
                     input int ea, input int ep, input int ed, input int eat,
                     input int eo, input int ef, input int eac);
    vec_t v;
    v = '{cv, acc, kv, kc, se, ea, ep, ed, eat, eo, ef, eac};
    vt.push_back(v);
  endtask

  int n, op, target;
  int ds[4];

  initial begin
    rst = 1'b1; card_valid = 1'b0; key_valid = 1'b0; session_end = 1'b0;
    card_acc_num = '0; key_code = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    //   cv acc kv kc se | acc  pin   dc att ok fail act
    add(1,  3, 0, 0, 0,   3,    0,   0, 3, 0, 0, 0);
    add(0,  0, 1, 3, 0,   3,    3,   1, 3, 0, 0, 0);
    add(0,  0, 1, 4, 0,   3,   34,   2, 3, 0, 0, 0);
    add(0,  0, 1, 5, 0,   3,  345,   3, 3, 0, 0, 0);
    add(0,  0, 1, 6, 0,   3, 3456,   4, 3, 0, 0, 0);
    add(0,  0, 1,10, 0,   3, 3456,   4, 3, 0, 0, 0);
    add(0,  0, 0, 0, 0,   3,    0,   0, 3, 1, 0, 1);
    add(0,  0, 0, 0, 0,   3,    0,   0, 3, 0, 0, 1);
    add(0,  0, 0, 0, 1,   0,    0,   0, 3, 0, 0, 0);
    add(1,  2, 0, 0, 0,   2,    0,   0, 3, 0, 0, 0);
    add(0,  0, 1, 9, 0,   2,    9,   1, 3, 0, 0, 0);
    add(0,  0, 1, 9, 0,   2,   99,   2, 3, 0, 0, 0);
    add(0,  0, 1,11, 0,   2,    0,   0, 3, 0, 0, 0);
    add(0,  0, 1, 2, 0,   2,    2,   1, 3, 0, 0, 0);
    add(0,  0, 1, 3, 0,   2,   23,   2, 3, 0, 0, 0);
    add(0,  0, 1, 4, 0,   2,  234,   3, 3, 0, 0, 0);
    add(0,  0, 1, 5, 0,   2, 2345,   4, 3, 0, 0, 0);
    add(0,  0, 1, 7, 0,   2, 2345,   4, 3, 0, 0, 0);
    add(0,  0, 1,10, 0,   2, 2345,   4, 3, 0, 0, 0);
    add(0,  0, 0, 0, 0,   2,    0,   0, 3, 1, 0, 1);
    add(0,  0, 1,12, 0,   0,    0,   0, 3, 0, 0, 0);
    add(1, 12, 0, 0, 0,  12,    0,   0, 3, 0, 0, 0);
    add(0,  0, 1, 1, 0,  12,    1,   1, 3, 0, 0, 0);
    add(0,  0, 1, 2, 0,  12,   12,   2, 3, 0, 0, 0);
    add(0,  0, 1, 3, 0,  12,  123,   3, 3, 0, 0, 0);
    add(0,  0, 1, 4, 0,  12, 1234,   4, 3, 0, 0, 0);
    add(0,  0, 1,10, 0,  12, 1234,   4, 3, 0, 0, 0);
    add(0,  0, 0, 0, 0,   0,    0,   0, 3, 0, 1, 0);
    add(0,  0, 0, 0, 0,   0,    0,   0, 3, 0, 0, 0);
    add(0,  0, 1, 5, 0,   0,    0,   0, 3, 0, 0, 0);

    foreach (vt[i]) begin
      drive(vt[i].cv, vt[i].acc, vt[i].kv, vt[i].kc, vt[i].se);
      check($sformatf("vec%0d.acc_num", i),        32'(acc_num),        vt[i].e_acc);
      check($sformatf("vec%0d.pin", i),            32'(pin),            vt[i].e_pin);
      check($sformatf("vec%0d.digit_count", i),    32'(digit_count),    vt[i].e_dc);
      check($sformatf("vec%0d.attempts_left", i),  32'(attempts_left),  vt[i].e_att);
      check($sformatf("vec%0d.auth_ok", i),        32'(auth_ok),        vt[i].e_ok);
      check($sformatf("vec%0d.auth_fail", i),      32'(auth_fail),      vt[i].e_fail);
      check($sformatf("vec%0d.session_active", i), 32'(session_active), vt[i].e_act);
    end

    // Three wrong PINs on a known account, then a lockout of exactly LCK cycles.
    card(1);
    for (int t = 0; t < MAX_ATT; t++) begin
      for (int d = 0; d < PD; d++) key(1);
      key(10);
      check("lock.checked_pin", 32'(pin), 1111);
      tick();
      check("lock.auth_fail", 32'(auth_fail), 1);
      check("lock.attempts_left", 32'(attempts_left), MAX_ATT - 1 - t);
      check("lock.locked", 32'(locked), (t == MAX_ATT - 1) ? 1 : 0);
    end
    n = 1;
    while (locked === 1'b1 && n < LCK + 10) begin
      if (n == 5) drive(1, 5, 1, 3, 0);
      else tick();
      if (locked === 1'b1) n++;
    end
    check("lock.duration", 32'(n), LCK);
    check("lock.exit_attempts", 32'(attempts_left), MAX_ATT);
    check("lock.exit_acc_num", 32'(acc_num), 0);

    // Short ENTER is ignored; then inactivity abandons the entry.
    card(5); key(5); key(6); key(10);
    check("tmo.short_enter_dc", 32'(digit_count), 2);
    tick();
    check("tmo.short_enter_no_fail", 32'(auth_fail), 0);
    n = 1;
    while (timeout !== 1'b1 && n < TMO + 10) begin
      tick();
      n++;
    end
    check("tmo.idle_cycles", 32'(n), TMO);
    check("tmo.acc_num", 32'(acc_num), 0);
    check("tmo.pin", 32'(pin), 0);
    check("tmo.attempts_left", 32'(attempts_left), MAX_ATT);
    check("tmo.no_auth_ok", 32'(auth_ok), 0);

    // A key landing on the expiry cycle keeps the entry alive.
    card(5); key(5);
    idle(TMO - 1);
    key(6);
    check("tmo_race.timeout", 32'(timeout), 0);
    check("tmo_race.digit_count", 32'(digit_count), 2);
    check("tmo_race.acc_num", 32'(acc_num), 5);
    idle(3);
    key(12);
    check("tmo_race.cancel_acc", 32'(acc_num), 0);

    // Reset mid-entry and mid-lockout.
    card(7); key(1); key(2);
    check("rst_entry.pre_dc", 32'(digit_count), 2);
    pulse_reset();
    check_reset("rst_entry");
    card(1);
    for (int t = 0; t < MAX_ATT; t++) begin
      for (int d = 0; d < PD; d++) key(1);
      key(10);
      tick();
    end
    idle(10);
    check("rst_lock.pre_locked", 32'(locked), 1);
    pulse_reset();
    check_reset("rst_lock");

    // Randomized sessions against the model.
    for (int it = 0; it < 250; it++) begin
      op = int'($urandom_range(0, 9));
      case (op)
        0, 1: card(int'($urandom_range(0, 15)));
        2, 3, 4: begin
          if (m_acc < 10 && $urandom_range(0, 1) == 1) target = pin_of(m_acc);
          else target = int'($urandom_range(0, 9999));
          ds[0] = target / 1000;
          ds[1] = (target / 100) % 10;
          ds[2] = (target / 10) % 10;
          ds[3] = target % 10;
          for (int d = 0; d < PD; d++) begin
            key(ds[d]);
            idle(int'($urandom_range(0, 2)));
          end
          key(10);
          idle(1);
        end
        5, 6: drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 1,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        7: drive(0, 0, 0, 0, 1);
        8: idle(int'($urandom_range(0, 50)));
        default: begin
          key(int'($urandom_range(0, 9)));
          key(10);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
